// File: rtl/ula.sv
// nRisc ALU: combines two operands under a 3-bit op code; result and zero flag
// are registered together so the flag can never disagree with the result.
module ula #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       ULAOp,
  input  logic [WIDTH-1:0] Dado1,
  input  logic [WIDTH-1:0] Dado2,
  output logic             zero,
  output logic [WIDTH-1:0] Resultado
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SLT = 3'b100,
    OP_XOR = 3'b101,
    OP_SRL = 3'b110,
    OP_SLL = 3'b111
  } op_e;

  logic [WIDTH-1:0] res_nxt;
  logic [2:0]       shamt;

  // only the low three bits of B act as shift amount
  assign shamt = Dado2[2:0];

  always_comb begin
    res_nxt = '0;
    case (ULAOp)
      OP_ADD:  res_nxt = Dado1 + Dado2;
      OP_SUB:  res_nxt = Dado1 - Dado2;
      OP_AND:  res_nxt = Dado1 & Dado2;
      OP_OR:   res_nxt = Dado1 | Dado2;
      OP_SLT:  res_nxt = {{(WIDTH-1){1'b0}}, ($signed(Dado1) < $signed(Dado2))};
      OP_XOR:  res_nxt = Dado1 ^ Dado2;
      OP_SRL:  res_nxt = Dado1 >> shamt;
      OP_SLL:  res_nxt = Dado1 << shamt;
      default: res_nxt = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Resultado <= '0;
      zero      <= 1'b1;
    end else begin
      Resultado <= res_nxt;
      zero      <= (res_nxt == '0);
    end
  end

endmodule

// File: tb/tb_ula.sv
// Bench for ula: directed corner cases plus a random pipelined stream,
// checked against an integer-arithmetic model of the operation table.
module tb_ula;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] ULAOp = 3'b000;
  logic [7:0] Dado1 = 8'h00;
  logic [7:0] Dado2 = 8'h00;
  logic       zero;
  logic [7:0] Resultado;

  int total = 0;
  int bad   = 0;

  ula #(.WIDTH(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .ULAOp    (ULAOp),
    .Dado1    (Dado1),
    .Dado2    (Dado2),
    .zero     (zero),
    .Resultado(Resultado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic int sval(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic int model(input int op, input int a, input int b);
    int s;
    s = b % 8;
    case (op)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return a & b;
      3: return a | b;
      4: return (sval(a) < sval(b)) ? 1 : 0;
      5: return a ^ b;
      6: return a / (1 << s);
      default: return (a * (1 << s)) % 256;
    endcase
  endfunction

  // drive, clock once, then check the captured result and flag
  task automatic run_op(input string tag, input int op, input int a, input int b, input int exp);
    ULAOp = op[2:0];
    Dado1 = a[7:0];
    Dado2 = b[7:0];
    @(posedge clock);
    #1;
    chk({tag, ".res"}, Resultado, exp[7:0]);
    chk({tag, ".zero"}, {7'd0, zero}, {7'd0, exp == 0});
  endtask

  initial begin
    int ops[$];
    int as[$];
    int bs[$];

    // asynchronous reset before any clock edge
    #1 reset = 1'b1;
    #1;
    chk("rst.res", Resultado, 8'h00);
    chk("rst.zero", {7'd0, zero}, 8'h01);
    @(posedge clock); #1;
    reset = 1'b0;

    // basic ops, A=2 B=1
    run_op("add", 0, 2, 1, 3);
    run_op("sub", 1, 2, 1, 1);
    run_op("and", 2, 2, 1, 0);
    run_op("or",  3, 2, 1, 3);
    run_op("slt", 4, 2, 1, 0);
    run_op("xor", 5, 2, 1, 3);

    // equality compare then inequality
    run_op("eq",  5, 2, 2, 0);
    run_op("neq", 5, 2, 1, 3);

    // wrap and sign
    run_op("addwrap", 0, 255, 1, 0);
    run_op("subwrap", 1, 1, 2, 255);
    run_op("sltneg",  4, 128, 1, 1);
    run_op("sltpos",  4, 1, 128, 0);

    // shifts with A=0x81
    run_op("srl3",  6, 8'h81, 3, 8'h10);
    run_op("sll3",  7, 8'h81, 3, 8'h08);
    run_op("srlB",  6, 8'h81, 8'h0B, 8'h10);
    run_op("sllB",  7, 8'h81, 8'h0B, 8'h08);
    run_op("srl0",  6, 8'h81, 0, 8'h81);
    run_op("sll0",  7, 8'h81, 0, 8'h81);

    // latency: inputs changed mid-cycle must not show until the next edge
    run_op("lat0", 0, 2, 1, 3);
    ULAOp = 3'b010; Dado1 = 8'h0F; Dado2 = 8'hF0;
    #3;
    chk("lat.hold.res", Resultado, 8'h03);
    chk("lat.hold.zero", {7'd0, zero}, 8'h00);
    @(posedge clock); #1;
    chk("lat.upd.res", Resultado, 8'h00);
    chk("lat.upd.zero", {7'd0, zero}, 8'h01);

    // reset mid-stream from 0x03/0
    run_op("prerst", 3, 2, 1, 3);
    ULAOp = 3'b000; Dado1 = 8'h10; Dado2 = 8'h20;
    #2 reset = 1'b1;
    #1;
    chk("mrst.res", Resultado, 8'h00);
    chk("mrst.zero", {7'd0, zero}, 8'h01);
    repeat (3) @(posedge clock);
    #1;
    chk("mrst.hold.res", Resultado, 8'h00);
    chk("mrst.hold.zero", {7'd0, zero}, 8'h01);
    reset = 1'b0;
    @(posedge clock); #1;
    chk("mrst.resume.res", Resultado, 8'h30);
    chk("mrst.resume.zero", {7'd0, zero}, 8'h00);

    // random back-to-back stream, one op per cycle, scored one edge later
    for (int i = 0; i < 300; i++) begin
      ops.push_back($urandom_range(0, 7));
      as.push_back($urandom_range(0, 255));
      bs.push_back((i % 16 == 0) ? as[i] : $urandom_range(0, 255));
    end
    for (int i = 0; i < 300; i++) begin
      int e;
      ULAOp = ops[i][2:0];
      Dado1 = as[i][7:0];
      Dado2 = bs[i][7:0];
      @(posedge clock); #1;
      e = model(ops[i], as[i], bs[i]);
      chk($sformatf("rnd%0d.op%0d.res", i, ops[i]), Resultado, e[7:0]);
      chk($sformatf("rnd%0d.zero", i), {7'd0, zero}, {7'd0, e == 0});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
